// File: rtl/sparse_xw_engine_pkg.sv
// Shared types and fixed-point saturation helpers for the GCN sparse X*W datapath.
package gcn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam int SAT_W = 64;
  typedef logic signed [SAT_W-1:0] wide_t;

  function automatic wide_t sat_max(input int w);
    return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t sat_min(input int w);
    return -(wide_t'(1) <<< (w - 1));
  endfunction

  function automatic logic sat_hit(input wide_t v, input int w);
    return (v > sat_max(w)) || (v < sat_min(w));
  endfunction

  function automatic wide_t sat_clamp(input wide_t v, input int w);
    if (v > sat_max(w)) return sat_max(w);
    if (v < sat_min(w)) return sat_min(w);
    return v;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic idx_ok(input int unsigned idx, input int unsigned n);
    return idx < n;
  endfunction

endpackage

// File: rtl/sparse_xw_engine_if.sv
// Host-side bundle of sparse_xw_engine: weight writes, nonzero stream, result drain, status.
// Row indices are sized for OUT_ROWS+1 so an out-of-range row stays representable at power-of-two depths.
interface sparse_xw_engine_if import gcn_pkg::*; #(
  parameter int DATA_W   = 16,
  parameter int W_ROWS   = 32,
  parameter int N_COLS   = 2,
  parameter int OUT_ROWS = 100
);
  localparam int WRW = idx_w(W_ROWS);
  localparam int CW  = idx_w(N_COLS);
  localparam int RW  = $clog2(OUT_ROWS + 1);

  logic                     i_w_valid;
  logic [WRW-1:0]           i_w_row;
  logic [CW-1:0]            i_w_col;
  logic [DATA_W-1:0]        i_w_data;
  logic                     i_start;
  logic                     i_nz_valid;
  logic                     o_nz_ready;
  logic [RW-1:0]            i_nz_row;
  logic [WRW-1:0]           i_nz_col;
  logic [DATA_W-1:0]        i_nz_data;
  logic                     i_nz_last;
  logic                     o_out_valid;
  logic                     i_out_ready;
  logic [RW-1:0]            o_out_row;
  logic [N_COLS*DATA_W-1:0] o_out_data;
  logic                     o_out_last;
  logic                     o_busy;
  logic                     o_sat;
  logic                     o_err;

  modport master (
    output i_w_valid, i_w_row, i_w_col, i_w_data, i_start,
    output i_nz_valid, i_nz_row, i_nz_col, i_nz_data, i_nz_last, i_out_ready,
    input  o_nz_ready, o_out_valid, o_out_row, o_out_data, o_out_last, o_busy, o_sat, o_err
  );

  modport slave (
    input  i_w_valid, i_w_row, i_w_col, i_w_data, i_start,
    input  i_nz_valid, i_nz_row, i_nz_col, i_nz_data, i_nz_last, i_out_ready,
    output o_nz_ready, o_out_valid, o_out_row, o_out_data, o_out_last, o_busy, o_sat, o_err
  );

endinterface

// File: rtl/sparse_xw_engine_lane.sv
// One output column: S2 multiply/shift/saturate, S3 saturating accumulate with same-row forwarding.
// Two registered stages after the S1 weight read; never stalls, no backpressure.
module xw_mac_lane import gcn_pkg::*; #(
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     vld_i,
  input  logic                     fwd_i,
  input  logic signed [DATA_W-1:0] w_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic signed [DATA_W-1:0] acc_i,
  output logic signed [DATA_W-1:0] sum_o,
  output logic                     sat_o
);

  logic signed [2*DATA_W-1:0] prod_full;
  wide_t                      prod_wide;
  wide_t                      sum_wide;
  logic signed [DATA_W-1:0]   prod_d, prod_q, acc_q, sum_q, base;
  logic                       prod_sat_d, prod_sat_q, vld_q;

  always_comb begin
    prod_full  = (2*DATA_W)'(w_i) * (2*DATA_W)'(x_i);
    prod_wide  = wide_t'(prod_full >>> FRAC_BITS);
    prod_d     = DATA_W'(sat_clamp(prod_wide, DATA_W));
    prod_sat_d = sat_hit(prod_wide, DATA_W);
    // The previous triplet's sum is not yet visible in acc_i when it hit the same row.
    base       = fwd_i ? sum_q : acc_q;
    sum_wide   = wide_t'(base) + wide_t'(prod_q);
    sum_o      = DATA_W'(sat_clamp(sum_wide, DATA_W));
    sat_o      = vld_q && (prod_sat_q || sat_hit(sum_wide, DATA_W));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q      <= 1'b0;
      prod_q     <= '0;
      prod_sat_q <= 1'b0;
      acc_q      <= '0;
      sum_q      <= '0;
    end else begin
      vld_q <= vld_i;
      if (vld_i) begin
        prod_q     <= prod_d;
        prod_sat_q <= prod_sat_d;
        acc_q      <= acc_i;
      end
      if (vld_q) sum_q <= sum_o;
    end
  end

endmodule

// File: rtl/sparse_xw_engine.sv
// COO sparse X times local dense W; accumulator written 3 cycles after triplet acceptance, 3-cycle flush.
// Nonzeros accepted every cycle in ACCUM; drain is valid/ready, output held while the consumer stalls.
module sparse_xw_engine import gcn_pkg::*; #(
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int W_ROWS    = 32,
  parameter int N_COLS    = 2,
  parameter int OUT_ROWS  = 100
) (
  input logic               clk,
  input logic               rst,
  sparse_xw_engine_if.slave bus
);

  localparam int RW = $clog2(OUT_ROWS + 1);
  localparam int AW = idx_w(OUT_ROWS);
  localparam int LW = N_COLS * DATA_W;

  state_e              state_q, state_d;
  logic [1:0]          flush_cnt_q, flush_cnt_d;
  logic                start_go, nz_acc, nz_ok, fwd;
  logic [LW-1:0]       w_mem_q   [W_ROWS];
  logic [LW-1:0]       acc_mem_q [OUT_ROWS];
  logic [OUT_ROWS-1:0] touched_q;
  logic                s1_vld_q, s2_vld_q, s3_vld_q;
  logic [AW-1:0]       s1_row_q, s2_row_q, s3_row_q;
  logic [LW-1:0]       s1_w_q, s1_acc, sum_row;
  logic [DATA_W-1:0]   s1_x_q;
  logic [N_COLS-1:0]   lane_sat;
  logic                out_vld_q, out_last_q, drain_load, out_hs;
  logic [RW-1:0]       out_row_q, out_row_nxt;
  logic [LW-1:0]       out_dat_q, drain_rd;
  logic                sat_q, err_q;

  always_comb begin
    start_go    = bus.i_start && (state_q == IDLE);
    nz_acc      = bus.i_nz_valid && (state_q == ACCUM);
    nz_ok       = idx_ok(32'(bus.i_nz_row), OUT_ROWS) && idx_ok(32'(bus.i_nz_col), W_ROWS);
    fwd         = s3_vld_q && (s3_row_q == s2_row_q);
    // Untouched rows read as zero, so a pass never needs a bulk clear.
    s1_acc      = touched_q[s1_row_q] ? acc_mem_q[s1_row_q] : '0;
    drain_load  = (state_q == FLUSH) && (flush_cnt_q == 2'd2);
    out_hs      = out_vld_q && bus.i_out_ready;
    out_row_nxt = drain_load ? '0 : out_row_q + RW'(1);
    drain_rd    = touched_q[out_row_nxt[AW-1:0]] ? acc_mem_q[out_row_nxt[AW-1:0]] : '0;
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      IDLE:  if (bus.i_start) state_d = ACCUM;
      ACCUM: if (nz_acc && bus.i_nz_last) begin
        state_d     = FLUSH;
        flush_cnt_d = 2'd0;
      end
      FLUSH: if (flush_cnt_q == 2'd2) state_d = DRAIN;
             else flush_cnt_d = flush_cnt_q + 2'd1;
      DRAIN: if (out_hs && out_last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      flush_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.i_w_valid && (state_q == IDLE) && idx_ok(32'(bus.i_w_row), W_ROWS)
        && idx_ok(32'(bus.i_w_col), N_COLS))
      w_mem_q[bus.i_w_row][bus.i_w_col*DATA_W +: DATA_W] <= bus.i_w_data;
    if (s2_vld_q) acc_mem_q[s2_row_q] <= sum_row;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s3_vld_q  <= 1'b0;
      s1_row_q  <= '0;
      s2_row_q  <= '0;
      s3_row_q  <= '0;
      s1_w_q    <= '0;
      s1_x_q    <= '0;
      touched_q <= '0;
      sat_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      s1_vld_q <= nz_acc && nz_ok;
      if (nz_acc) begin
        s1_row_q <= bus.i_nz_row[AW-1:0];
        s1_w_q   <= w_mem_q[bus.i_nz_col];
        s1_x_q   <= bus.i_nz_data;
      end
      s2_vld_q <= s1_vld_q;
      s2_row_q <= s1_row_q;
      s3_vld_q <= s2_vld_q;
      s3_row_q <= s2_row_q;
      if (start_go)      touched_q <= '0;
      else if (s2_vld_q) touched_q[s2_row_q] <= 1'b1;
      if (start_go)        sat_q <= 1'b0;
      else if (|lane_sat)  sat_q <= 1'b1;
      if (start_go)                err_q <= 1'b0;
      else if (nz_acc && !nz_ok)   err_q <= 1'b1;
    end
  end

  for (genvar c = 0; c < N_COLS; c++) begin : g_lane
    xw_mac_lane #(.DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .vld_i (s1_vld_q),
      .fwd_i (fwd),
      .w_i   (s1_w_q[c*DATA_W +: DATA_W]),
      .x_i   (s1_x_q),
      .acc_i (s1_acc[c*DATA_W +: DATA_W]),
      .sum_o (sum_row[c*DATA_W +: DATA_W]),
      .sat_o (lane_sat[c])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_vld_q  <= 1'b0;
      out_row_q  <= '0;
      out_dat_q  <= '0;
      out_last_q <= 1'b0;
    end else if (drain_load || (out_hs && !out_last_q)) begin
      out_vld_q  <= 1'b1;
      out_row_q  <= out_row_nxt;
      out_dat_q  <= drain_rd;
      out_last_q <= (out_row_nxt == RW'(OUT_ROWS - 1));
    end else if (out_hs) begin
      out_vld_q  <= 1'b0;
      out_row_q  <= '0;
      out_dat_q  <= '0;
      out_last_q <= 1'b0;
    end
  end

  assign bus.o_nz_ready  = (state_q == ACCUM);
  assign bus.o_busy      = (state_q != IDLE);
  assign bus.o_out_valid = out_vld_q;
  assign bus.o_out_row   = out_row_q;
  assign bus.o_out_data  = out_dat_q;
  assign bus.o_out_last  = out_last_q;
  assign bus.o_sat       = sat_q;
  assign bus.o_err       = err_q;

endmodule

// File: tb/tb_sparse_xw_engine.sv
// Directed bench for sparse_xw_engine with a 4-row, 2-column configuration.
module tb_sparse_xw_engine;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [31:0] exp_rows [4];

  always #5 clk = ~clk;

  sparse_xw_engine_if #(.DATA_W(16), .W_ROWS(32), .N_COLS(2), .OUT_ROWS(4)) bus ();

  sparse_xw_engine #(
    .DATA_W(16), .FRAC_BITS(8), .W_ROWS(32), .N_COLS(2), .OUT_ROWS(4)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr_w(input logic [4:0] row, input logic col, input logic [15:0] dat);
    bus.i_w_valid = 1'b1;
    bus.i_w_row   = row;
    bus.i_w_col   = col;
    bus.i_w_data  = dat;
    @(negedge clk);
    bus.i_w_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic nz(input logic [2:0] row, input logic [4:0] col, input logic [15:0] dat,
                    input logic last);
    int n;
    n = 0;
    bus.i_nz_valid = 1'b1;
    bus.i_nz_row   = row;
    bus.i_nz_col   = col;
    bus.i_nz_data  = dat;
    bus.i_nz_last  = last;
    while (!bus.o_nz_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) chk("nz_ready timeout", 32'(bus.o_nz_ready), 32'd1);
    @(negedge clk);
    bus.i_nz_valid = 1'b0;
    bus.i_nz_last  = 1'b0;
  endtask

  task automatic set_exp(input logic [31:0] r0, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] r3);
    exp_rows[0] = r0;
    exp_rows[1] = r1;
    exp_rows[2] = r2;
    exp_rows[3] = r3;
  endtask

  // stall[k] drops i_out_ready in the k-th cycle after the first valid row.
  task automatic drain(input string tag, input logic [7:0] stall);
    int n, k, r;
    n = 0;
    while (!bus.o_out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " first_vld_lat"}, 32'(n), 32'd3);
    r = 0;
    k = 0;
    while (r < 4 && k < 40) begin
      bus.i_out_ready = !(k < 8 && stall[k[2:0]]);
      chk($sformatf("%s row%0d vld", tag, r),  32'(bus.o_out_valid), 32'd1);
      chk($sformatf("%s row%0d idx", tag, r),  32'(bus.o_out_row),   32'(r));
      chk($sformatf("%s row%0d dat", tag, r),  bus.o_out_data,       exp_rows[r]);
      chk($sformatf("%s row%0d last", tag, r), 32'(bus.o_out_last),  32'(r == 3));
      if (bus.i_out_ready) r++;
      @(negedge clk);
      k++;
    end
    bus.i_out_ready = 1'b1;
    chk({tag, " drain_cycles"}, 32'(k), 32'(4 + $countones(stall)));
    chk({tag, " idle_vld"},  32'(bus.o_out_valid), 32'd0);
    chk({tag, " idle_busy"}, 32'(bus.o_busy),      32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " nz_ready"},  32'(bus.o_nz_ready),  32'd0);
    chk({tag, " out_valid"}, 32'(bus.o_out_valid), 32'd0);
    chk({tag, " out_row"},   32'(bus.o_out_row),   32'd0);
    chk({tag, " out_data"},  bus.o_out_data,       32'd0);
    chk({tag, " out_last"},  32'(bus.o_out_last),  32'd0);
    chk({tag, " busy"},      32'(bus.o_busy),      32'd0);
    chk({tag, " sat"},       32'(bus.o_sat),       32'd0);
    chk({tag, " err"},       32'(bus.o_err),       32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    bus.i_w_valid   = 1'b0;
    bus.i_w_row     = '0;
    bus.i_w_col     = '0;
    bus.i_w_data    = '0;
    bus.i_start     = 1'b0;
    bus.i_nz_valid  = 1'b0;
    bus.i_nz_row    = '0;
    bus.i_nz_col    = '0;
    bus.i_nz_data   = '0;
    bus.i_nz_last   = 1'b0;
    bus.i_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic: 1.5 * {2.0, -1.0}
    wr_w(5'd3, 1'b0, 16'h0200);
    wr_w(5'd3, 1'b1, 16'hFF00);
    pulse_start();
    chk("basic busy_after_start", 32'(bus.o_busy), 32'd1);
    chk("basic nz_ready", 32'(bus.o_nz_ready), 32'd1);
    nz(3'd1, 5'd3, 16'h0180, 1'b1);
    set_exp(32'h0, 32'hFE80_0300, 32'h0, 32'h0);
    drain("basic", 8'h00);
    chk("basic sat", 32'(bus.o_sat), 32'd0);
    chk("basic err", 32'(bus.o_err), 32'd0);

    // Forwarding: three back-to-back hits on row 2
    pulse_start();
    nz(3'd2, 5'd3, 16'h0100, 1'b0);
    nz(3'd2, 5'd3, 16'h0100, 1'b0);
    nz(3'd2, 5'd3, 16'h0100, 1'b1);
    set_exp(32'h0, 32'h0, 32'hFD00_0600, 32'h0);
    drain("fwd", 8'h00);

    // Saturation on both the product and the accumulation
    wr_w(5'd0, 1'b0, 16'h7FFF);
    wr_w(5'd0, 1'b1, 16'h7FFF);
    pulse_start();
    nz(3'd0, 5'd0, 16'h7FFF, 1'b0);
    nz(3'd0, 5'd0, 16'h7FFF, 1'b1);
    set_exp(32'h7FFF_7FFF, 32'h0, 32'h0, 32'h0);
    drain("sat", 8'h00);
    chk("sat flag", 32'(bus.o_sat), 32'd1);
    chk("sat err", 32'(bus.o_err), 32'd0);

    // Range: dropped last triplet still flushes; previous rows must read as zero
    pulse_start();
    chk("range sat_cleared", 32'(bus.o_sat), 32'd0);
    nz(3'd4, 5'd0, 16'h0100, 1'b1);
    set_exp(32'h0, 32'h0, 32'h0, 32'h0);
    drain("range", 8'h00);
    chk("range err", 32'(bus.o_err), 32'd1);

    // Backpressure: ready 1-0-0-1
    pulse_start();
    chk("bp err_cleared", 32'(bus.o_err), 32'd0);
    nz(3'd1, 5'd3, 16'h0180, 1'b0);
    nz(3'd3, 5'd3, 16'h0100, 1'b1);
    set_exp(32'h0, 32'hFE80_0300, 32'h0, 32'hFF00_0200);
    drain("bp", 8'b0000_0110);

    // Reset in the middle of ACCUM
    pulse_start();
    nz(3'd1, 5'd3, 16'h0100, 1'b0);
    nz(3'd1, 5'd3, 16'h0100, 1'b0);
    nz(3'd5, 5'd0, 16'h0100, 1'b0);
    chk("midrst err_before", 32'(bus.o_err), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst asserted");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midrst released");
    pulse_start();
    nz(3'd2, 5'd3, 16'h0100, 1'b1);
    set_exp(32'h0, 32'h0, 32'hFF00_0200, 32'h0);
    drain("midrst pass", 8'h00);
    chk("midrst err_after", 32'(bus.o_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
